inst_decode_stage: RTL and testbench

// Registered RV32/RV64 instruction decode stage between fetch and execute.

---
 rtl/inst_decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_inst_decode_stage.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_stage.sv
// Registered RV32/RV64 decode stage: decodes one instruction per cycle into a small
// FIFO whose head is held in a dedicated register, so the outputs never depend on i_ready.
module inst_decode_stage #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_inst_valid,
    output logic            o_inst_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [6:0]      o_op,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [9:0]      o_func,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic            o_illegal,
    output logic [XLEN-1:0] o_pc,
    output logic [CW-1:0]   o_count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [6:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [9:0]      func;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    entry_t             dec;
    logic signed [31:0] imm32;

    always_comb begin
        dec      = '0;
        imm32    = '0;
        dec.op   = i_inst[6:0];
        dec.func = {i_inst[31:25], i_inst[14:12]};
        dec.pc   = i_pc;
        dec.fmt  = FMT_ILL;
        if (i_inst[1:0] == 2'b11) begin
            case (i_inst[6:0])
                7'b0110011: dec.fmt = FMT_R;
                7'b1100111, 7'b0000011, 7'b0010011,
                7'b0001111, 7'b1110011: dec.fmt = FMT_I;
                7'b0100011: dec.fmt = FMT_S;
                7'b1100011: dec.fmt = FMT_B;
                7'b0110111, 7'b0010111: dec.fmt = FMT_U;
                7'b1101111: dec.fmt = FMT_J;
                7'b0111011: if (XLEN == 64) dec.fmt = FMT_R;
                7'b0011011: if (XLEN == 64) dec.fmt = FMT_I;
                default: dec.fmt = FMT_ILL;
            endcase
        end
        dec.illegal = (dec.fmt == FMT_ILL);
        // Register fields a format does not encode are forced to zero.
        case (dec.fmt)
            FMT_R: begin
                dec.rd  = i_inst[11:7];
                dec.rs1 = i_inst[19:15];
                dec.rs2 = i_inst[24:20];
            end
            FMT_I: begin
                dec.rd  = i_inst[11:7];
                dec.rs1 = i_inst[19:15];
                imm32   = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            FMT_S: begin
                dec.rs1 = i_inst[19:15];
                dec.rs2 = i_inst[24:20];
                imm32   = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            FMT_B: begin
                dec.rs1 = i_inst[19:15];
                dec.rs2 = i_inst[24:20];
                imm32   = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                           i_inst[11:8], 1'b0};
            end
            FMT_U: begin
                dec.rd = i_inst[11:7];
                imm32  = {i_inst[31:12], 12'b0};
            end
            FMT_J: begin
                dec.rd = i_inst[11:7];
                imm32  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                          i_inst[30:21], 1'b0};
            end
            default: imm32 = '0;
        endcase
        dec.imm = XLEN'(imm32);
    end

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    entry_t        head_q, head_d;
    entry_t        mem_q [FIFO_DEPTH];
    logic          push, pop;

    assign o_inst_ready = (count_q != DEPTH_C);
    assign o_valid      = (count_q != '0);
    assign push         = i_inst_valid && o_inst_ready && !i_flush;
    assign pop          = o_valid && i_ready && !i_flush;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        head_d   = head_q;
        if (i_flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // The head register tracks whichever entry will sit at the read pointer next
            // cycle; with nothing left it keeps the last delivered entry.
            if (push && (count_q == '0 || (pop && count_q == CW'(1))))
                head_d = dec;
            else if (pop && count_q > CW'(1))
                head_d = mem_q[ptr_inc(rd_ptr_q)];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    assign o_op      = head_q.op;
    assign o_rd      = head_q.rd;
    assign o_rs1     = head_q.rs1;
    assign o_rs2     = head_q.rs2;
    assign o_func    = head_q.func;
    assign o_imm     = head_q.imm;
    assign o_fmt     = head_q.fmt;
    assign o_illegal = head_q.illegal;
    assign o_pc      = head_q.pc;
    assign o_count   = count_q;
endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed and random checks of inst_decode_stage: an RV32 and an RV64 instance share
// the same input stimulus; expected entries come from hand-built vectors and an encoder.
module tb_inst_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_inst_valid, i_flush, i_ready;
    logic [31:0] i_inst;
    logic [63:0] i_pc;

    logic        o_inst_ready, o_valid, o_illegal;
    logic [6:0]  o_op;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [9:0]  o_func;
    logic [31:0] o_imm, o_pc;
    logic [2:0]  o_fmt;
    logic [1:0]  o_count;

    logic        o_inst_ready64, o_valid64, o_illegal64;
    logic [6:0]  o_op64;
    logic [4:0]  o_rd64, o_rs1_64, o_rs2_64;
    logic [9:0]  o_func64;
    logic [63:0] o_imm64, o_pc64;
    logic [2:0]  o_fmt64;
    logic [1:0]  o_count64;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [9:0]  func;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] pc;
    } exp_t;
    exp_t exp_q[$];

    inst_decode_stage #(.XLEN(32), .FIFO_DEPTH(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
        .i_inst(i_inst), .i_pc(i_pc[31:0]), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_op(o_op), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_func(o_func), .o_imm(o_imm), .o_fmt(o_fmt), .o_illegal(o_illegal),
        .o_pc(o_pc), .o_count(o_count)
    );

    inst_decode_stage #(.XLEN(64), .FIFO_DEPTH(2)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready64),
        .i_inst(i_inst), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid64),
        .i_ready(i_ready), .o_op(o_op64), .o_rd(o_rd64), .o_rs1(o_rs1_64), .o_rs2(o_rs2_64),
        .o_func(o_func64), .o_imm(o_imm64), .o_fmt(o_fmt64), .o_illegal(o_illegal64),
        .o_pc(o_pc64), .o_count(o_count64)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] inst, input logic [2:0] fmt,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [63:0] imm,
                                input logic [63:0] pc);
        exp_t e;
        e.op   = inst[6:0];
        e.func = {inst[31:25], inst[14:12]};
        e.fmt  = fmt;
        e.ill  = (fmt == 3'd7);
        e.rd   = rd;
        e.rs1  = rs1;
        e.rs2  = rs2;
        e.imm  = imm;
        e.pc   = pc;
        return e;
    endfunction

    // Encoder: picks a format and an immediate, builds the word, and records what the
    // decoder must reproduce from it.
    function automatic exp_t gen(input int k, input logic [63:0] pc, output logic [31:0] inst);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7, op;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [19:0] u20;
        logic [20:0] j21;
        exp_t        e;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        f7  = 7'($urandom_range(0, 127));
        i12 = 12'($urandom);
        b13 = {12'($urandom), 1'b0};
        u20 = 20'($urandom);
        j21 = {20'($urandom), 1'b0};
        case (k)
            0: begin
                inst = {f7, rs2, rs1, f3, rd, 7'b0110011};
                e = mk(inst, 3'd0, rd, rs1, rs2, 64'd0, pc);
            end
            1: begin
                case ($urandom_range(0, 4))
                    0: op = 7'b1100111;
                    1: op = 7'b0000011;
                    2: op = 7'b0010011;
                    3: op = 7'b0001111;
                    default: op = 7'b1110011;
                endcase
                inst = {i12, rs1, f3, rd, op};
                e = mk(inst, 3'd1, rd, rs1, 5'd0, {{52{i12[11]}}, i12}, pc);
            end
            2: begin
                inst = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'b0100011};
                e = mk(inst, 3'd2, 5'd0, rs1, rs2, {{52{i12[11]}}, i12}, pc);
            end
            3: begin
                inst = {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], 7'b1100011};
                e = mk(inst, 3'd3, 5'd0, rs1, rs2, {{51{b13[12]}}, b13}, pc);
            end
            4: begin
                op   = f3[0] ? 7'b0110111 : 7'b0010111;
                inst = {u20, rd, op};
                e = mk(inst, 3'd4, rd, 5'd0, 5'd0, {{32{u20[19]}}, u20, 12'd0}, pc);
            end
            default: begin
                inst = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'b1101111};
                e = mk(inst, 3'd5, rd, 5'd0, 5'd0, {{43{j21[20]}}, j21}, pc);
            end
        endcase
        return e;
    endfunction

    // Scoreboard: compares both heads with the oldest expected entry.
    task automatic check_head(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty when a head was expected", tag);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".valid"},   o_valid,   1);
        chk({tag, ".op"},      o_op,      e.op);
        chk({tag, ".rd"},      o_rd,      e.rd);
        chk({tag, ".rs1"},     o_rs1,     e.rs1);
        chk({tag, ".rs2"},     o_rs2,     e.rs2);
        chk({tag, ".func"},    o_func,    e.func);
        chk({tag, ".imm"},     o_imm,     e.imm[31:0]);
        chk({tag, ".fmt"},     o_fmt,     e.fmt);
        chk({tag, ".illegal"}, o_illegal, e.ill);
        chk({tag, ".pc"},      o_pc,      e.pc[31:0]);
        chk({tag, ".valid64"}, o_valid64, 1);
        chk({tag, ".imm64"},   o_imm64,   e.imm);
        chk({tag, ".fmt64"},   o_fmt64,   e.fmt);
        chk({tag, ".pc64"},    o_pc64,    e.pc);
    endtask

    // Driver
    task automatic push_one(input logic [31:0] inst, input logic [63:0] pc);
        i_inst       = inst;
        i_pc         = pc;
        i_inst_valid = 1'b1;
        tick();
        i_inst_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        exp_t        e;
        rst_n = 1'b0; i_inst_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_inst = '0; i_pc = '0;
        repeat (3) tick();
        chk("rst.count", o_count, 0);
        chk("rst.valid", o_valid, 0);
        chk("rst.ready", o_inst_ready, 1);
        chk("rst.imm", o_imm, 0);
        chk("rst.pc64", o_pc64, 0);
        chk("rst.fmt", o_fmt, 0);
        rst_n = 1'b1;
        tick();

        // addi x1,x0,-1, then the queue drains and the outputs hold
        i_ready = 1'b1;
        exp_q.push_back(mk(32'hFFF00093, 3'd1, 5'd1, 5'd0, 5'd0, '1, 64'h100));
        push_one(32'hFFF00093, 64'h100);
        check_head("addi");
        tick();
        chk("drain.valid", o_valid, 0);
        chk("drain.count", o_count, 0);
        chk("drain.hold_rd", o_rd, 1);

        // lui, jal -4, beq +8, then two illegal words, back to back
        exp_q.push_back(mk(32'h123452B7, 3'd4, 5'd5, 5'd0, 5'd0, 64'h12345000, 64'h104));
        push_one(32'h123452B7, 64'h104);
        check_head("lui");
        exp_q.push_back(mk(32'hFFDFF06F, 3'd5, 5'd0, 5'd0, 5'd0, -64'sd4, 64'h108));
        push_one(32'hFFDFF06F, 64'h108);
        check_head("jal");
        exp_q.push_back(mk(32'h00000463, 3'd3, 5'd0, 5'd0, 5'd0, 64'd8, 64'h10C));
        push_one(32'h00000463, 64'h10C);
        check_head("beq");
        exp_q.push_back(mk(32'h00000000, 3'd7, 5'd0, 5'd0, 5'd0, 64'd0, 64'h110));
        push_one(32'h00000000, 64'h110);
        check_head("ill0");
        exp_q.push_back(mk(32'h0000007F, 3'd7, 5'd0, 5'd0, 5'd0, 64'd0, 64'h114));
        push_one(32'h0000007F, 64'h114);
        check_head("ill7f");
        tick();
        chk("ill.drain", o_count, 0);

        // Backpressure: two fill the queue, the third waits until space frees
        i_ready = 1'b0;
        i_inst_valid = 1'b1;
        i_inst = 32'h00100113; i_pc = 64'h200;
        exp_q.push_back(mk(32'h00100113, 3'd1, 5'd2, 5'd0, 5'd0, 64'd1, 64'h200));
        tick();
        i_inst = 32'h00208233; i_pc = 64'h204;
        exp_q.push_back(mk(32'h00208233, 3'd0, 5'd4, 5'd1, 5'd2, 64'd0, 64'h204));
        tick();
        chk("full.count", o_count, 2);
        chk("full.ready", o_inst_ready, 0);
        check_head("bp_a");
        i_inst = 32'h00312023; i_pc = 64'h208;
        tick();
        chk("held.count", o_count, 2);
        chk("held.ready", o_inst_ready, 0);
        i_ready = 1'b1;
        tick();
        chk("pop_full.count", o_count, 1);
        chk("pop_full.ready", o_inst_ready, 1);
        check_head("bp_b");
        exp_q.push_back(mk(32'h00312023, 3'd2, 5'd0, 5'd2, 5'd3, 64'd0, 64'h208));
        tick();
        i_inst_valid = 1'b0;
        chk("bp_c.count", o_count, 1);
        check_head("bp_c");
        tick();
        chk("bp.empty", o_valid, 0);

        // Flush with a full queue, offered input and downstream ready all together
        i_ready = 1'b0;
        push_one(32'h00100093, 64'h300);
        push_one(32'h00200093, 64'h304);
        chk("pre_flush.count", o_count, 2);
        i_inst = 32'h00300093; i_pc = 64'h308; i_inst_valid = 1'b1;
        i_flush = 1'b1; i_ready = 1'b1;
        tick();
        i_flush = 1'b0; i_inst_valid = 1'b0;
        chk("flush.count", o_count, 0);
        chk("flush.valid", o_valid, 0);
        chk("flush.ready", o_inst_ready, 1);
        tick();
        chk("flush.no_drop_in", o_valid, 0);
        // Flush with room to accept: the offered word must still vanish
        push_one(32'h00400093, 64'h30C);
        i_inst = 32'h00500093; i_pc = 64'h310; i_inst_valid = 1'b1; i_flush = 1'b1;
        tick();
        i_flush = 1'b0; i_inst_valid = 1'b0;
        chk("flush2.count", o_count, 0);
        chk("flush2.valid64", o_valid64, 0);
        exp_q.push_back(mk(32'h00600093, 3'd1, 5'd1, 5'd0, 5'd0, 64'd6, 64'h314));
        push_one(32'h00600093, 64'h314);
        check_head("post_flush");
        tick();

        // Asynchronous reset in the middle of a cycle empties the queue at once
        i_ready = 1'b0;
        push_one(32'hFFF00093, 64'h400);
        chk("pre_rst.count", o_count, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst.count", o_count, 0);
        chk("mid_rst.valid", o_valid, 0);
        chk("mid_rst.ready", o_inst_ready, 1);
        chk("mid_rst.imm64", o_imm64, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // RV64-only R opcode: illegal on the 32-bit instance, R on the 64-bit one
        i_ready = 1'b1;
        push_one(32'h40B5053B, 64'h500);
        chk("w.ill32", o_illegal, 1);
        chk("w.fmt32", o_fmt, 7);
        chk("w.rd32", o_rd, 0);
        chk("w.ill64", o_illegal64, 0);
        chk("w.fmt64", o_fmt64, 0);
        chk("w.rd64", o_rd64, 10);
        chk("w.rs2_64", o_rs2_64, 11);
        tick();

        // Sustained random legal stream, one instruction in and out every cycle
        for (int i = 0; i <= 100; i++) begin
            if (i > 0) begin
                check_head($sformatf("rnd%0d", i));
                chk("rnd.count", o_count, 1);
            end
            if (i < 100) begin
                i_pc = {$urandom, $urandom};
                e = gen($urandom_range(0, 5), i_pc, w);
                i_inst = w;
                i_inst_valid = 1'b1;
                exp_q.push_back(e);
            end else begin
                i_inst_valid = 1'b0;
            end
            tick();
        end
        chk("rnd.end_count", o_count, 0);
        chk("rnd.sb_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
